// File: rtl/tiny_cpu_multicycle.sv
// tiny_cpu_multicycle
//   Multicycle 8-bit teaching CPU (add/lw/sw/j on four registers).
//   Each instruction takes three steps (FETCH, EXEC, WB).  A clock-enable
//   divider paces the steps.  The last value written is shown on two
//   active-low 7-segment digits as a decimal number from 00 to 99.
//
// Ports
//   clk50        in   system clock
//   reset        in   asynchronous, active-high reset
//   instruction  in   ROM word at ReadAddress (combinational ROM)
//   ReadAddress  out  current PC
//   seg_ten      out  tens digit, active-low {g,f,e,d,c,b,a}
//   seg_one      out  ones digit, same encoding
//
// Instruction: [7:6] op (00 add, 01 lw, 10 sw, 11 j), [5:4] rs, [3:2] rt,
//              [1:0] rd / signed imm2; j uses signed [5:0] as its offset.
module tiny_cpu_multicycle #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DMEM_DEPTH = 32,
    parameter int unsigned PC_W       = 8,
    parameter int unsigned CLK_DIV    = 25000000
) (
    input  logic            clk50,
    input  logic            reset,
    input  logic [7:0]      instruction,
    output logic [PC_W-1:0] ReadAddress,
    output logic [6:0]      seg_ten,
    output logic [6:0]      seg_one
);

    localparam int unsigned AW    = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_LW = 2'b01, OP_SW = 2'b10, OP_J = 2'b11} op_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q;
    logic               tick;
    logic [PC_W-1:0]    pc_q;
    logic [7:0]         ir_q;
    logic [DATA_W-1:0]  alu_q;
    logic [PC_W-1:0]    jtgt_q;
    logic [AW-1:0]      addr_q;
    logic [DATA_W-1:0]  disp_q;
    logic [DATA_W-1:0]  rf_q   [4];
    logic [DATA_W-1:0]  dmem_q [DMEM_DEPTH];

    op_t                op;
    logic [1:0]         rs, rt, rd;
    logic [DATA_W-1:0]  imm_ext;

    // ---------------- step divider ----------------
    // With CLK_DIV=1 the divider stays at 0, so the tick is constant 1.
    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                S_FETCH: state_d = S_EXEC;
                S_EXEC:  state_d = S_WB;
                default: state_d = S_FETCH;
            endcase
        end
    end

    // ---------------- decode ----------------
    assign op      = op_t'(ir_q[7:6]);
    assign rs      = ir_q[5:4];
    assign rt      = ir_q[3:2];
    assign rd      = ir_q[1:0];
    assign imm_ext = DATA_W'($signed(ir_q[1:0]));

    // ---------------- datapath ----------------
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            pc_q   <= '0;
            ir_q   <= '0;
            alu_q  <= '0;
            jtgt_q <= '0;
            addr_q <= '0;
            disp_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                rf_q[i] <= DATA_W'(i);
            end
            for (int unsigned i = 0; i < DMEM_DEPTH; i++) begin
                dmem_q[i] <= DATA_W'(i);
            end
        end else if (tick) begin
            case (state_q)
                S_FETCH: begin
                    ir_q <= instruction;
                end
                S_EXEC: begin
                    case (op)
                        OP_ADD: alu_q  <= rf_q[rs] + rf_q[rt];
                        OP_LW,
                        OP_SW:  addr_q <= AW'(rf_q[rs] + imm_ext);
                        default: jtgt_q <= pc_q + PC_W'(1) + PC_W'($signed(ir_q[5:0]));
                    endcase
                end
                default: begin
                    case (op)
                        OP_ADD: begin
                            rf_q[rd] <= alu_q;
                            disp_q   <= alu_q;
                        end
                        OP_LW: begin
                            rf_q[rt] <= dmem_q[addr_q];
                            disp_q   <= dmem_q[addr_q];
                        end
                        OP_SW: begin
                            dmem_q[addr_q] <= rf_q[rt];
                            disp_q         <= rf_q[rt];
                        end
                        default: ;
                    endcase
                    pc_q <= (op == OP_J) ? jtgt_q : pc_q + PC_W'(1);
                end
            endcase
        end
    end

    assign ReadAddress = pc_q;

    // ---------------- display ----------------
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            default: seg7 = 7'b0010000;
        endcase
    endfunction

    logic [DATA_W-1:0] disp_mod;
    logic [3:0]        tens_d, ones_d;

    always_comb begin
        disp_mod = disp_q % DATA_W'(100);
        tens_d   = 4'(disp_mod / DATA_W'(10));
        ones_d   = 4'(disp_mod % DATA_W'(10));
    end

    assign seg_ten = seg7(tens_d);
    assign seg_one = seg7(ones_d);

endmodule
